// File: rtl/arm_pkg.sv
// Shared ARM pipeline types and constants.
package arm_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } if_state_t;

endpackage

// File: rtl/MUX.sv
// Generic two-input word multiplexer.
module MUX #(
  parameter int unsigned LENGTH = 32
) (
  input  logic              sel_i,
  input  logic [LENGTH-1:0] in0_i,
  input  logic [LENGTH-1:0] in1_i,
  output logic [LENGTH-1:0] out_o
);

  // sel_i=1 picks in1_i
  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {pc, instruction, valid} with flush, load and bubble.
module if_id_reg
  import arm_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            valid_q;

  // Flush clears everything; a bubble keeps pc but marks the slot empty; otherwise hold
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end else if (bubble_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, IF/ID register,
// hazard freeze and branch flush.
module if_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        valid_out
);

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            req_q;

  logic [XLEN-1:0] pc_inc_c;
  logic [XLEN-1:0] pc_alt_c;
  logic            use_branch_c;
  logic            ifid_flush_c;
  logic            ifid_load_c;
  logic            ifid_bubble_c;
  logic [XLEN-1:0] ifid_instr_c;

  // Sequential next address; wraps modulo 2^32
  assign pc_inc_c = pc_q + PC_INC;

  // Next-state, next-pc source and IF/ID control
  always_comb begin
    state_d       = state_q;
    redirect_d    = redirect_q;
    hold_d        = hold_q;
    pc_alt_c      = pc_q;
    use_branch_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    ifid_load_c   = 1'b0;
    ifid_bubble_c = 1'b0;
    ifid_instr_c  = imem_rdata;

    case (state_q)
      FETCH: begin
        if (imem_valid) begin
          if (branch_taken) begin
            use_branch_c = 1'b1;
            ifid_flush_c = 1'b1;
          end else if (freeze) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            ifid_load_c = 1'b1;
            pc_alt_c    = pc_inc_c;
          end
        end else if (branch_taken) begin
          // Request still in flight: keep its address, remember the target
          redirect_d   = branch_addr;
          ifid_flush_c = 1'b1;
          state_d      = DROP;
        end else if (!freeze) begin
          ifid_bubble_c = 1'b1;
        end
      end

      HOLD: begin
        ifid_instr_c = hold_q;
        if (branch_taken) begin
          use_branch_c = 1'b1;
          ifid_flush_c = 1'b1;
          state_d      = FETCH;
        end else if (!freeze) begin
          ifid_load_c = 1'b1;
          pc_alt_c    = pc_inc_c;
          state_d     = FETCH;
        end
      end

      DROP: begin
        // Outputs stay flushed until the abandoned response drains
        ifid_flush_c = 1'b1;
        if (branch_taken) begin
          redirect_d = branch_addr;
        end
        if (imem_valid) begin
          pc_alt_c     = redirect_q;
          use_branch_c = branch_taken;
          state_d      = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // A fresh branch target overrides every other next-pc source
  MUX #(.LENGTH(XLEN)) u_pc_mux (
    .sel_i (use_branch_c),
    .in0_i (pc_alt_c),
    .in1_i (branch_addr),
    .out_o (pc_d)
  );

  // Fetch-side state; imem_req is registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      redirect_q <= '0;
      hold_q     <= '0;
      req_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      hold_q     <= hold_d;
      req_q      <= (state_d != HOLD);
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;

  if_id_reg u_if_id_reg (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (ifid_flush_c),
    .load_i   (ifid_load_c),
    .bubble_i (ifid_bubble_c),
    .pc_i     (pc_inc_c),
    .instr_i  (ifid_instr_c),
    .pc_o     (pc_out),
    .instr_o  (instruction),
    .valid_o  (valid_out)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: latency-programmable memory model plus an output scoreboard.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] MAGIC  = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid_out;

  int n_pass  = 0;
  int n_total = 0;
  int mem_lat = 0;
  int mem_cnt = 0;

  logic [63:0] exp_q[$];
  logic        prev_v     = 1'b0;
  logic [31:0] prev_pc    = '0;
  logic [31:0] prev_instr = '0;
  logic [31:0] cur;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .pc_out       (pc_out),
    .instruction  (instruction),
    .valid_out    (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive the memory response, clock, score any newly delivered instruction
  task automatic tick();
    logic        req_was;
    logic        valid_was;
    logic        rst_was;
    logic [63:0] e;
    if (imem_req === 1'b1 && !rst && mem_cnt >= mem_lat) begin
      imem_valid = 1'b1;
      imem_rdata = imem_addr ^ MAGIC;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
    req_was   = (imem_req === 1'b1);
    valid_was = imem_valid;
    rst_was   = rst;
    @(posedge clk);
    #1;
    if (valid_out === 1'b1 &&
        (!prev_v || pc_out !== prev_pc || instruction !== prev_instr)) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no new output",
                 pc_out, instruction);
      end else begin
        e = exp_q.pop_front();
        if ({pc_out, instruction} !== e)
          $display("FAIL sb_output: got pc=%h instr=%h, expected pc=%h instr=%h",
                   pc_out, instruction, e[63:32], e[31:0]);
        else n_pass++;
      end
    end
    prev_v     = (valid_out === 1'b1);
    prev_pc    = pc_out;
    prev_instr = instruction;
    if (rst_was) mem_cnt = 0;
    else if (req_was && valid_was) mem_cnt = 0;
    else if (req_was) mem_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_valid = 1'b0; imem_rdata = '0; mem_lat = 0; mem_cnt = 0;
    tick();
    tick();
    n_total++;
    if ({pc_out, instruction, valid_out} !== 65'd0)
      $display("FAIL reset_outputs: got pc=%h instr=%h v=%b, expected zeros",
               pc_out, instruction, valid_out);
    else n_pass++;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC)
      $display("FAIL reset_req: got req=%b addr=%h, expected req=1 addr=%h",
               imem_req, imem_addr, RST_PC);
    else n_pass++;
    rst = 1'b0;
    cur = RST_PC;
  endtask

  task automatic test_sequential();
    mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (imem_addr !== cur) $display("FAIL seq_addr: got %h expected %h", imem_addr, cur);
      else n_pass++;
      exp_q.push_back({cur + 32'd4, cur ^ MAGIC});
      tick();
      n_total++;
      if (valid_out !== 1'b1 || pc_out !== cur + 32'd4)
        $display("FAIL seq_out: got v=%b pc=%h expected v=1 pc=%h",
                 valid_out, pc_out, cur + 32'd4);
      else n_pass++;
      cur = cur + 32'd4;
    end
  endtask

  task automatic test_latency();
    mem_lat = 2;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (imem_addr !== cur || imem_req !== 1'b1)
          $display("FAIL lat_addr: got req=%b addr=%h expected req=1 addr=%h",
                   imem_req, imem_addr, cur);
        else n_pass++;
        if (k == 2) exp_q.push_back({cur + 32'd4, cur ^ MAGIC});
        tick();
        n_total++;
        if (valid_out !== (k == 2))
          $display("FAIL lat_valid: got %b expected %b (wait %0d)", valid_out, (k == 2), k);
        else n_pass++;
      end
      cur = cur + 32'd4;
    end
  endtask

  task automatic test_freeze();
    mem_lat = 0;
    freeze  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (valid_out !== 1'b1 || pc_out !== cur || imem_req !== 1'b0)
        $display("FAIL freeze_hold: got v=%b pc=%h req=%b expected v=1 pc=%h req=0",
                 valid_out, pc_out, imem_req, cur);
      else n_pass++;
    end
    freeze = 1'b0;
    exp_q.push_back({cur + 32'd4, cur ^ MAGIC});
    tick();
    cur = cur + 32'd4;
    n_total++;
    if (imem_addr !== cur || imem_req !== 1'b1)
      $display("FAIL freeze_resume: got req=%b addr=%h expected req=1 addr=%h",
               imem_req, imem_addr, cur);
    else n_pass++;
    exp_q.push_back({cur + 32'd4, cur ^ MAGIC});
    tick();
    cur = cur + 32'd4;
  endtask

  task automatic test_branch_drop();
    mem_lat = 3;
    tick();
    branch_taken = 1'b1; branch_addr = 32'h180;
    tick();
    n_total++;
    if ({pc_out, instruction, valid_out} !== 65'd0 || imem_addr !== cur || imem_req !== 1'b1)
      $display("FAIL drop_flush: got pc=%h instr=%h v=%b addr=%h expected zeros addr=%h",
               pc_out, instruction, valid_out, imem_addr, cur);
    else n_pass++;
    branch_addr = 32'h100;
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < 8 && imem_addr === cur; i++) begin
      tick();
      n_total++;
      if (valid_out !== 1'b0) $display("FAIL drop_leak: got v=%b expected 0", valid_out);
      else n_pass++;
    end
    n_total++;
    if (imem_addr !== 32'h100) $display("FAIL drop_target: got %h expected 00000100", imem_addr);
    else n_pass++;
    cur = 32'h100;
    mem_lat = 0;
    exp_q.push_back({cur + 32'd4, cur ^ MAGIC});
    tick();
    cur = cur + 32'd4;
  endtask

  task automatic test_branch_freeze();
    freeze = 1'b1;
    tick();
    n_total++;
    if (imem_req !== 1'b0 || pc_out !== cur || valid_out !== 1'b1)
      $display("FAIL hold_enter: got req=%b pc=%h v=%b expected req=0 pc=%h v=1",
               imem_req, pc_out, valid_out, cur);
    else n_pass++;
    branch_taken = 1'b1; branch_addr = 32'h200;
    tick();
    n_total++;
    if ({pc_out, instruction, valid_out} !== 65'd0 || imem_addr !== 32'h200 || imem_req !== 1'b1)
      $display("FAIL hold_flush: got pc=%h instr=%h v=%b addr=%h req=%b expected zeros addr=00000200 req=1",
               pc_out, instruction, valid_out, imem_addr, imem_req);
    else n_pass++;
    branch_taken = 1'b0; freeze = 1'b0;
    cur = 32'h200;
    exp_q.push_back({cur + 32'd4, cur ^ MAGIC});
    tick();
    cur = cur + 32'd4;
  endtask

  task automatic test_reset_midreq();
    mem_lat = 3;
    tick();
    n_total++;
    if (valid_out !== 1'b0 || pc_out !== cur)
      $display("FAIL bubble: got v=%b pc=%h expected v=0 pc=%h", valid_out, pc_out, cur);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_total++;
    if ({pc_out, instruction, valid_out} !== 65'd0 || imem_addr !== RST_PC || imem_req !== 1'b1)
      $display("FAIL midreq_reset: got pc=%h instr=%h v=%b addr=%h req=%b expected zeros addr=%h req=1",
               pc_out, instruction, valid_out, imem_addr, imem_req, RST_PC);
    else n_pass++;
    rst = 1'b0;
    mem_lat = 0;
    exp_q.push_back({RST_PC + 32'd4, RST_PC ^ MAGIC});
    tick();
    n_total++;
    if (imem_addr !== 32'h0) $display("FAIL wrap_addr: got %h expected 00000000", imem_addr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_latency();
    test_freeze();
    test_branch_drop();
    test_branch_freeze();
    test_reset_midreq();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the ARM pipeline, directly upstream of the decode stage. It holds the program counter and fetches one instruction at a time over a request/valid handshake with instruction memory. It registers pc+4 and the fetched instruction toward decode, and applies hazard freeze and branch flush. It contains the IF/ID pipeline register, so its outputs connect directly to decode's `pc_in` and `instruction` inputs.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  — the only clock; all state changes on its rising edge.
- `rst`  in  1  — reset, synchronous and active-high.
- `freeze`  in  1  — hazard stall from the hazard unit; holds the outputs and the PC.
- `branch_taken`  in  1  — branch resolved in EXE; redirects fetch and flushes the stage.
- `branch_addr`  in  32  — branch target; sampled only when `branch_taken`=1.
- `imem_req`  out  1  — fetch request to instruction memory.
- `imem_addr`  out  32  — fetch address; stable while `imem_req`=1.
- `imem_rdata`  in  32  — instruction word; sampled only when `imem_valid`=1.
- `imem_valid`  in  1  — read data valid; may assert in the same cycle as `imem_req` or any later cycle.
- `pc_out`  out  32  — registered fetch address + 4, to decode `pc_in`.
- `instruction`  out  32  — registered instruction, to decode.
- `valid_out`  out  1  — registered; 1 means `instruction` is real, 0 means a bubble.

## Operation

Internal state:
- `pc_reg`: next fetch address.
- `redirect_reg`: 32-bit pending branch target.
- `hold_buf`: 32-bit captured instruction.
- State machine with states FETCH, HOLD, DROP.
- Only one request is outstanding at any time.

FETCH:
- Drives `imem_req`=1 and `imem_addr`=`pc_reg`.
- `imem_valid`=1 and `branch_taken`=1: discard the data, `pc_reg`←`branch_addr`, flush the outputs, stay in FETCH.
- `imem_valid`=1, `branch_taken`=0, `freeze`=1: `hold_buf`←`imem_rdata`, outputs unchanged, go to HOLD.
- `imem_valid`=1, no branch, no freeze: outputs←{`pc_reg`+4, `imem_rdata`, 1}, `pc_reg`←`pc_reg`+4.
- `imem_valid`=0 and `branch_taken`=1: `redirect_reg`←`branch_addr`, flush the outputs, go to DROP. `imem_addr` must not change mid-request.
- `imem_valid`=0, no branch, `freeze`=1: outputs hold.
- `imem_valid`=0, no branch, no freeze: insert a bubble (`valid_out`←0, `instruction`←NOP_INSTR); `pc_out` holds.

HOLD:
- Drives `imem_req`=0.
- `branch_taken`=1: discard `hold_buf`, `pc_reg`←`branch_addr`, flush the outputs, go to FETCH.
- No branch, `freeze`=0: outputs←{`pc_reg`+4, `hold_buf`, 1}, `pc_reg`←`pc_reg`+4, go to FETCH.
- Otherwise stay in HOLD with outputs unchanged.

DROP:
- Keeps `imem_req`=1 at the old `pc_reg`; outputs stay flushed.
- A further `branch_taken` overwrites `redirect_reg`.
- On `imem_valid`=1: discard the data, `pc_reg`←`redirect_reg`, or `branch_addr` if `branch_taken`=1 in the same cycle, then go to FETCH.

Flush:
- `valid_out`←0, `instruction`←NOP_INSTR (32'h0), `pc_out`←0.

Priority:
- rst > `branch_taken` > `freeze` > normal advance.
- `branch_taken` together with `freeze` always flushes.

Arithmetic:
- `pc_reg`+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 with no flag.
- Low two address bits are not checked.

## Timing

Reset values (rst=1 at an edge):
- State FETCH, `pc_reg`=`RESET_PC`, `redirect_reg`=0, `hold_buf`=0.
- `pc_out`=0, `instruction`=0, `valid_out`=0.
- `imem_req`=1 from the first cycle after reset.
- Reset mid-request abandons the request. Instruction memory shares `rst` and must not return data for an abandoned request.

Latency and throughput:
- `imem_valid` at edge N puts the instruction on the outputs after edge N.
- With same-cycle `imem_valid`, throughput is 1 instruction per cycle.
- Each memory wait cycle costs one bubble.

Branch and freeze:
- Branch penalty: the outputs are flushed at the `branch_taken` edge.
- The target is fetched from the next cycle in FETCH/HOLD, or after the outstanding response in DROP.
- `freeze` holds the outputs in the same edge it is sampled; release resumes in one cycle from HOLD.

## Structure

- Shared package `arm_pkg`:
  - `if_state_t` enum {FETCH, HOLD, DROP}.
  - `NOP_INSTR` = 32'h0000_0000.
  - `PC_INC` = 4.
- The next-pc select reuses the existing `MUX` (LENGTH 32) module.
- The single natural sub-module is `if_id_reg`: the {`pc_out`, `instruction`, `valid_out`} register with synchronous flush and hold enable.

## Test plan

1. Reset, then same-cycle memory returning `addr`^32'hA5A5_0000 → `imem_addr` 0,4,8,…; `pc_out` 4,8,12 on consecutive cycles with `valid_out`=1.
2. Memory latency of 3 cycles → two bubbles (`valid_out`=0) between instructions; `imem_addr` stable during each wait.
3. `freeze` for 4 cycles while a response arrives → outputs stay on the old instruction; on release `instruction`=the buffered word and the next fetch goes to `pc_reg`+4.
4. `branch_taken` with `branch_addr`=32'h100 while a response is outstanding → DROP; the late data is never output; the next `imem_addr`=32'h100.
5. `branch_taken` and `freeze` together in HOLD → `valid_out`=0 and `instruction`=0 next cycle, then fetch from the target.
6. `RESET_PC`=32'hFFFF_FFFC → the second fetch is at 0; assert `rst` mid-request → outputs zero and `imem_addr`=`RESET_PC`.
